// File: rtl/pcie_mwr_tlp_builder.sv
`default_nettype none
// ============================================================================
// Module   : pcie_mwr_tlp_builder
// Brief    : Packs {address, length} write commands plus a 256-bit payload
//            stream into 4DW Memory Write TLPs on a 256-bit Avalon-ST source.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_mwr_tlp_builder #(
    parameter int MAX_PAYLOAD_DW = 64,
    parameter int TAG_W          = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:0]  req_id,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_addr,
    input  logic [9:0]   cmd_len_dw,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic [255:0] data,
    output logic         tx_st_valid,
    input  logic         tx_st_ready,
    output logic [255:0] tx_st_data,
    output logic         tx_st_sop,
    output logic         tx_st_eop,
    output logic [1:0]   tx_st_empty,
    output logic         busy,
    output logic         err_cmd,
    output logic [31:0]  tlp_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_LAST = 2'd3
    } state_t;

    localparam logic [10:0]      c_max_len = 11'(MAX_PAYLOAD_DW);
    localparam logic [TAG_W-1:0] c_tag_one = TAG_W'(1);

    state_t             state_q,     state_d;
    logic [61:0]        addr_q,      addr_d;
    logic [9:0]         len_q,       len_d;
    logic [15:0]        rid_q,       rid_d;
    logic [6:0]         left_q,      left_d;
    logic [127:0]       carry_q,     carry_d;
    logic [TAG_W-1:0]   tag_q,       tag_d;
    logic               last_sent_q, last_sent_d;
    logic [31:0]        count_q,     count_d;
    logic               err_q,       err_d;
    logic               cmd_rdy_q,   cmd_rdy_d;
    logic               tx_valid_q,  tx_valid_d;
    logic [255:0]       tx_data_q,   tx_data_d;
    logic               tx_sop_q,    tx_sop_d;
    logic               tx_eop_q,    tx_eop_d;
    logic [1:0]         tx_empty_q,  tx_empty_d;

    logic               w_load;
    logic               w_cmd_fire;
    logic               w_cmd_bad;
    logic               w_data_rdy;
    logic               w_data_fire;
    logic               w_eop_fire;
    logic [127:0]       w_hdr;
    logic               w_emit;
    logic [255:0]       w_beat_data;
    logic               w_beat_sop;
    logic               w_beat_eop;
    logic [1:0]         w_beat_empty;

    always_comb begin
        w_load      = !tx_valid_q || tx_st_ready;
        // cmd_ready_q is only ever high while the FSM sits in IDLE
        w_cmd_fire  = cmd_valid && cmd_rdy_q;
        w_cmd_bad   = (cmd_len_dw == 10'd0) || (cmd_len_dw[2:0] != 3'd0) ||
                      ({1'b0, cmd_len_dw} > c_max_len) || (cmd_addr[4:0] != 5'd0);
        w_data_rdy  = ((state_q == ST_HDR) || (state_q == ST_BODY)) && w_load;
        w_data_fire = w_data_rdy && data_valid;
        w_eop_fire  = tx_valid_q && tx_st_ready && tx_eop_q;
        w_hdr       = {{addr_q[29:0], 2'b00},
                       addr_q[61:30],
                       {rid_q, 8'(tag_q), 4'hF, 4'hF},
                       {3'b011, 5'd0, 14'd0, len_q}};

        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        rid_d        = rid_q;
        left_d       = left_q;
        carry_d      = carry_q;
        tag_d        = tag_q;
        last_sent_d  = last_sent_q;
        count_d      = count_q;
        err_d        = err_q;
        w_emit       = 1'b0;
        w_beat_data  = '0;
        w_beat_sop   = 1'b0;
        w_beat_eop   = 1'b0;
        w_beat_empty = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    if (w_cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr[63:2];
                        len_d   = cmd_len_dw;
                        rid_d   = req_id;
                        left_d  = cmd_len_dw[9:3];
                        state_d = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                if (w_data_fire) begin
                    w_emit      = 1'b1;
                    w_beat_data = {data[127:0], w_hdr};
                    w_beat_sop  = 1'b1;
                    carry_d     = data[255:128];
                    left_d      = left_q - 7'd1;
                    state_d     = (left_q == 7'd1) ? ST_LAST : ST_BODY;
                end
            end
            ST_BODY: begin
                if (w_data_fire) begin
                    w_emit      = 1'b1;
                    w_beat_data = {data[127:0], carry_q};
                    carry_d     = data[255:128];
                    left_d      = left_q - 7'd1;
                    if (left_q == 7'd1) begin
                        state_d = ST_LAST;
                    end
                end
            end
            default: begin
                // The tail beat holds the final 4 payload DWs; the FSM then
                // waits in LAST until the sink has taken it.
                if (!last_sent_q) begin
                    if (w_load) begin
                        w_emit       = 1'b1;
                        w_beat_data  = {128'h0, carry_q};
                        w_beat_eop   = 1'b1;
                        w_beat_empty = 2'b10;
                        last_sent_d  = 1'b1;
                    end
                end else if (w_eop_fire) begin
                    count_d     = count_q + 32'd1;
                    tag_d       = tag_q + c_tag_one;
                    last_sent_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
        endcase

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_sop_d   = tx_sop_q;
        tx_eop_d   = tx_eop_q;
        tx_empty_d = tx_empty_q;
        if (w_load) begin
            tx_valid_d = w_emit;
            if (w_emit) begin
                tx_data_d  = w_beat_data;
                tx_sop_d   = w_beat_sop;
                tx_eop_d   = w_beat_eop;
                tx_empty_d = w_beat_empty;
            end
        end

        cmd_rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rid_q       <= '0;
            left_q      <= '0;
            carry_q     <= '0;
            tag_q       <= '0;
            last_sent_q <= 1'b0;
            count_q     <= '0;
            err_q       <= 1'b0;
            cmd_rdy_q   <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
            tx_empty_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rid_q       <= rid_d;
            left_q      <= left_d;
            carry_q     <= carry_d;
            tag_q       <= tag_d;
            last_sent_q <= last_sent_d;
            count_q     <= count_d;
            err_q       <= err_d;
            cmd_rdy_q   <= cmd_rdy_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_sop_q    <= tx_sop_d;
            tx_eop_q    <= tx_eop_d;
            tx_empty_q  <= tx_empty_d;
        end
    end

    assign cmd_ready   = cmd_rdy_q;
    assign data_ready  = w_data_rdy;
    assign tx_st_valid = tx_valid_q;
    assign tx_st_data  = tx_data_q;
    assign tx_st_sop   = tx_sop_q;
    assign tx_st_eop   = tx_eop_q;
    assign tx_st_empty = tx_empty_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_cmd     = err_q;
    assign tlp_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_mwr_tlp_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_mwr_tlp_builder
// Brief    : Self-checking bench; expected TLPs are built as flat DW lists
//            (4 header DWs + payload) and cut into 8-DW beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_mwr_tlp_builder;

    logic         clock;
    logic         reset;
    logic [15:0]  req_id;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_addr;
    logic [9:0]   cmd_len_dw;
    logic         data_valid;
    logic         data_ready;
    logic [255:0] data;
    logic         tx_st_valid;
    logic         tx_st_ready;
    logic [255:0] tx_st_data;
    logic         tx_st_sop;
    logic         tx_st_eop;
    logic [1:0]   tx_st_empty;
    logic         busy;
    logic         err_cmd;
    logic [31:0]  tlp_count;

    pcie_mwr_tlp_builder #(.MAX_PAYLOAD_DW(64), .TAG_W(8)) dut (
        .clock(clock), .reset(reset), .req_id(req_id),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len_dw(cmd_len_dw), .data_valid(data_valid), .data_ready(data_ready),
        .data(data), .tx_st_valid(tx_st_valid), .tx_st_ready(tx_st_ready),
        .tx_st_data(tx_st_data), .tx_st_sop(tx_st_sop), .tx_st_eop(tx_st_eop),
        .tx_st_empty(tx_st_empty), .busy(busy), .err_cmd(err_cmd),
        .tlp_count(tlp_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           n_checks = 0;
    int           n_errors = 0;
    int           exp_tag = 0;
    int           exp_count = 0;
    int           last_latency = 0;
    logic [255:0] words [8];
    logic [31:0]  last_rx [$];
    logic [31:0]  ref_pl [$];

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                words[w][32*j +: 32] = $urandom;
    endtask

    task automatic fill_ramp16();
        for (int w = 0; w < 8; w++)
            for (int p = 0; p < 16; p++)
                words[w][16*p +: 16] = 16'(w*16 + p);
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0; tx_st_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_tag = 0; exp_count = 0;
    endtask

    // One command + its payload; rst_at>0 aborts with a reset after that many beats.
    task automatic run_tlp(input logic [63:0] addr, input int len, input int rdy_pct,
                           input int gap_after, input int gap_len, input int rst_at,
                           input int bub_mode, input string nm);
        logic [31:0]  tlp_dw [$];
        logic [31:0]  rx_dw [$];
        logic [255:0] exp_data, snap_data;
        logic [4:0]   snap_ctl;
        logic         done, cmd_done, sop_seen, stall, aborted, in_gap;
        int nb, beats, consumed, gap_left, cycles, bubbles, cmd_at, first_at, mism;
        tlp_dw = {}; rx_dw = {};
        tlp_dw.push_back(32'h6000_0000 | 32'(len));
        tlp_dw.push_back({req_id, 8'(exp_tag), 8'hFF});
        tlp_dw.push_back(addr[63:32]);
        tlp_dw.push_back({addr[31:2], 2'b00});
        for (int k = 0; k < len; k++) tlp_dw.push_back(words[k/8][32*(k%8) +: 32]);
        nb = len/8 + 1;
        done = 0; cmd_done = 0; sop_seen = 0; stall = 0; aborted = 0;
        beats = 0; consumed = 0; gap_left = gap_len; cycles = 0; bubbles = 0;
        cmd_at = 0; first_at = -1; snap_data = '0; snap_ctl = '0;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len_dw = 10'(len);
        while (!done && cycles < 2000) begin
            in_gap      = (consumed == gap_after) && (gap_left > 0);
            data_valid  = !in_gap && (consumed < len/8);
            data        = words[(consumed < 8) ? consumed : 7];
            tx_st_ready = int'($urandom_range(0, 99)) < rdy_pct;
            @(negedge clock);
            if (stall) begin
                chk({nm, "_hold_data"}, tx_st_data, snap_data);
                chk({nm, "_hold_ctl"}, 256'({tx_st_valid, tx_st_sop, tx_st_eop, tx_st_empty}),
                    256'(snap_ctl));
            end
            stall     = tx_st_valid && !tx_st_ready;
            snap_data = tx_st_data;
            snap_ctl  = {tx_st_valid, tx_st_sop, tx_st_eop, tx_st_empty};
            if (cmd_valid && cmd_ready) begin cmd_done = 1; cmd_at = cycles; end
            if (in_gap) gap_left--;
            if (data_valid && data_ready) consumed++;
            if (sop_seen && !tx_st_valid) bubbles++;
            if (tx_st_valid && first_at < 0) first_at = cycles;
            if (tx_st_valid && tx_st_ready) begin
                exp_data = '0;
                for (int j = 0; j < 8; j++)
                    if (8*beats + j < tlp_dw.size()) exp_data[32*j +: 32] = tlp_dw[8*beats + j];
                chk({nm, "_data"}, tx_st_data, exp_data);
                chk({nm, "_sop"}, 256'(tx_st_sop), 256'(beats == 0));
                chk({nm, "_eop"}, 256'(tx_st_eop), 256'(beats == nb-1));
                chk({nm, "_empty"}, 256'(tx_st_empty), 256'((beats == nb-1) ? 2 : 0));
                for (int j = 0; j < 8; j++) rx_dw.push_back(tx_st_data[32*j +: 32]);
                sop_seen = 1;
                beats++;
                if (tx_st_eop) done = 1;
            end
            if (rst_at > 0 && beats == rst_at) begin aborted = 1; break; end
            @(posedge clock);
            #1 cycles++;
            if (cmd_done) cmd_valid = 1'b0;
        end
        if (aborted) begin
            @(posedge clock);
            #1 reset = 1'b1; cmd_valid = 1'b0; data_valid = 1'b0;
            @(posedge clock);
            #1 reset = 1'b0;
            @(negedge clock);
            chk({nm, "_rst_valid"}, 256'(tx_st_valid), 256'(0));
            chk({nm, "_rst_data"}, tx_st_data, 256'(0));
            chk({nm, "_rst_ctl"}, 256'({tx_st_sop, tx_st_eop, tx_st_empty}), 256'(0));
            chk({nm, "_rst_hs"}, 256'({data_ready, cmd_ready, busy, err_cmd}), 256'(0));
            chk({nm, "_rst_count"}, 256'(tlp_count), 256'(0));
            exp_tag = 0; exp_count = 0;
            @(posedge clock);
            #1;
        end else begin
            chk({nm, "_done"}, 256'(done), 256'(1));
            chk({nm, "_beats"}, 256'(beats), 256'(nb));
            exp_count++;
            exp_tag = (exp_tag + 1) % 256;
            chk({nm, "_tlp_count"}, 256'(tlp_count), 256'(exp_count));
            chk({nm, "_idle"}, 256'(busy), 256'(0));
            mism = 0;
            for (int k = 0; k < len; k++)
                if (rx_dw.size() <= 4+k || rx_dw[4+k] !== words[k/8][32*(k%8) +: 32]) mism++;
            chk({nm, "_reassembly"}, 256'(mism), 256'(0));
            if (bub_mode == 0) chk({nm, "_no_bubbles"}, 256'(bubbles), 256'(0));
            if (bub_mode == 1) chk({nm, "_bubbles"}, 256'(bubbles > 0), 256'(1));
            last_latency = first_at - cmd_at;
        end
        last_rx = rx_dw;
        cmd_valid = 1'b0; data_valid = 1'b0;
    endtask

    task automatic bad_cmd(input logic [63:0] addr, input int len, input string nm);
        do_reset();
        @(posedge clock);
        #1;
        chk({nm, "_err_before"}, 256'(err_cmd), 256'(0));
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len_dw = 10'(len);
        data_valid = 1'b1; tx_st_ready = 1'b1;
        @(negedge clock);
        chk({nm, "_accepted"}, 256'(cmd_ready), 256'(1));
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk({nm, "_err"}, 256'(err_cmd), 256'(1));
            chk({nm, "_quiet"}, 256'({tx_st_valid, data_ready, busy}), 256'(0));
            chk({nm, "_cmd_ready"}, 256'(cmd_ready), 256'(1));
        end
        @(posedge clock);
        #1 data_valid = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dw;
        int mism;
        logic [15:0] hw;
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len_dw = '0;
        data_valid = 1'b0; data = '0; tx_st_ready = 1'b0; req_id = 16'hBEEF;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_valid", 256'(tx_st_valid), 256'(0));
        chk("reset_data", tx_st_data, 256'(0));
        chk("reset_ctl", 256'({tx_st_sop, tx_st_eop, tx_st_empty}), 256'(0));
        chk("reset_flags", 256'({cmd_ready, data_ready, busy, err_cmd}), 256'(0));
        chk("reset_count", 256'(tlp_count), 256'(0));
        @(posedge clock);
        #1;
        chk("reset_cmd_ready", 256'(cmd_ready), 256'(1));

        // Basic len=8 TLP with word-index payload
        for (int w = 0; w < 8; w++) words[w] = 256'(w);
        run_tlp(64'h0000_0000_3000_0000, 8, 100, -1, 0, 0, 0, "t1");
        dw = last_rx[0]; chk("t1_dw0", 256'(dw), 256'(32'h6000_0008));
        dw = last_rx[1]; chk("t1_req_id", 256'(dw[31:16]), 256'(16'hBEEF));
        chk("t1_tag", 256'(dw[15:8]), 256'(0));
        dw = last_rx[3]; chk("t1_dw3", 256'(dw), 256'(32'h3000_0000));
        chk("t1_latency", 256'(last_latency), 256'(2));

        // 64 DW halfword ramp under random backpressure
        fill_ramp16();
        run_tlp(64'h0000_0001_2345_6780, 64, 70, -1, 0, 0, -1, "t2");
        mism = 0;
        for (int h = 0; h < 128; h++) begin
            dw = last_rx[4 + h/2];
            hw = (h % 2 == 1) ? dw[31:16] : dw[15:0];
            if (hw !== 16'(h)) mism++;
        end
        chk("t2_ramp", 256'(mism), 256'(0));

        // Same payload, no stalls, then with a 5-cycle data gap
        run_tlp(64'h0000_0000_0000_4000, 64, 100, -1, 0, 0, 0, "t3_ref");
        ref_pl = {};
        for (int k = 0; k < 64; k++) ref_pl.push_back(last_rx[4+k]);
        run_tlp(64'h0000_0000_0000_4000, 64, 100, 3, 5, 0, 1, "t3_gap");
        mism = 0;
        for (int k = 0; k < 64; k++) if (last_rx[4+k] !== ref_pl[k]) mism++;
        chk("t3_same_payload", 256'(mism), 256'(0));

        // Random lengths, addresses, payload and backpressure
        for (int r = 0; r < 6; r++) begin
            fill_random();
            run_tlp({$urandom, $urandom & 32'hFFFF_FFE0}, 8*int'($urandom_range(1, 8)),
                    int'($urandom_range(40, 100)), -1, 0, 0, -1, "rand");
        end

        bad_cmd(64'h0, 12, "bad_len12");
        bad_cmd(64'h10, 8, "bad_align");
        bad_cmd(64'h0, 0, "bad_len0");
        bad_cmd(64'h0, 72, "bad_len72");

        // Reset during beat 2 of a len=32 TLP, then a clean TLP with tag 0
        do_reset();
        fill_random();
        run_tlp(64'h0000_0000_0000_8000, 32, 100, -1, 0, 2, -1, "t_rst");
        fill_random();
        run_tlp(64'h0000_0000_0000_9000, 8, 100, -1, 0, 0, 0, "t_post_rst");
        dw = last_rx[1]; chk("t_post_rst_tag", 256'(dw[15:8]), 256'(0));

        // 257 back-to-back len=8 TLPs: tags wrap 255 -> 0
        do_reset();
        for (int i = 0; i < 257; i++) begin
            fill_random();
            run_tlp({$urandom, $urandom & 32'hFFFF_FFE0}, 8, 100, -1, 0, 0, 0, "b2b");
        end
        dw = last_rx[1]; chk("b2b_last_tag", 256'(dw[15:8]), 256'(0));
        chk("b2b_count", 256'(tlp_count), 256'(257));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_mwr_tlp_builder.md
Name: pcie_mwr_tlp_builder

Overview:
- TX-side packetiser between the DMA data mover and the PCIe hard-IP Avalon-ST TX interface (256-bit, coreclkout_hip domain).
- Turns {address, length} write commands plus a 256-bit payload stream into 4DW Memory Write TLPs.
- Header occupies the low 128 bits of the first beat; payload is shifted by 128 bits across beats, giving the layout the endpoint bench checks.

Parameters:
- MAX_PAYLOAD_DW, 64, largest accepted cmd_len_dw (256 B max payload).
- TAG_W, 8, width of the internal tag counter.

Ports:
- clock  in  1  core clock (coreclkout_hip)
- reset  in  1  synchronous, active-high
- req_id  in  16  requester ID placed in header DW1[31:16]
- cmd_valid  in  1  command handshake
- cmd_ready  out  1  command handshake
- cmd_addr  in  64  byte address; bits [4:0] must be 0
- cmd_len_dw  in  10  payload length in DW; must be a nonzero multiple of 8, at most MAX_PAYLOAD_DW
- data_valid  in  1  payload handshake
- data_ready  out  1  payload handshake
- data  in  256  payload word; byte 0 in [7:0]
- tx_st_valid  out  1  Avalon-ST source
- tx_st_ready  in  1  Avalon-ST source
- tx_st_data  out  256  Avalon-ST source
- tx_st_sop  out  1  Avalon-ST source
- tx_st_eop  out  1  Avalon-ST source
- tx_st_empty  out  2  Avalon-ST source, in 64-bit units
- busy  out  1  high while not IDLE
- err_cmd  out  1  sticky; set on an invalid command
- tlp_count  out  32  TLPs fully sent, wraps

Behaviour:
- Reset values: all outputs 0, cmd_ready=0, tag=0, state IDLE. Reset mid-TLP abandons the packet; tx_st_valid is 0 on the cycle after reset.
- Output register: it loads when !tx_st_valid || tx_st_ready. tx_st_valid/data/sop/eop/empty hold stable while valid && !ready.
- cmd_ready = (state==IDLE). On acceptance, latch addr and N = cmd_len_dw/8 (beats of payload).
- Invalid command: len==0, len%8!=0, len>MAX, or addr[4:0]!=0.
  - Set err_cmd and stay IDLE; consume no data; emit no TLP.
- Header dwords, packed in tx_st_data[127:0] with DW0 in [31:0]:
  - DW0: Fmt=3'b011 at [31:29], Type=0 at [28:24], TC/attr=0, Length=cmd_len_dw at [9:0].
  - DW1: req_id at [31:16], tag at [15:8], LastBE=4'hF, FirstBE=4'hF.
  - DW2: addr[63:32].
  - DW3: {addr[31:2],2'b00}.
  - Always 4DW, even when addr[63:32]==0.
- State machine:
  - IDLE -> HDR on valid command.
  - HDR: when data_valid and the output register can load, emit {data[127:0], hdr} with sop=1, eop=0, empty=0. Assert data_ready that cycle; carry <= data[255:128]. Next state BODY if N>1, else LAST.
  - BODY: per consumed word, emit {data[127:0], carry} with sop=0, eop=0, empty=0; carry <= data[255:128]. After N-1 BODY beats go to LAST.
  - LAST: when the register can load, emit {128'h0, carry} with eop=1, empty=2'b10. Consume no data. When that beat is accepted (valid&&ready): tlp_count++, tag++ (wraps at 2^TAG_W), -> IDLE.
- Beat count: total beats = N+1. Payload bytes are in order across beats; the bench reassembles the original stream exactly.
- data_ready is asserted only in HDR/BODY with the output register loadable. data_valid low mid-packet inserts bubbles (tx_st_valid=0); packet content is unchanged.
- Latency:
  - Command accepted at cycle t, data valid at t+1: first beat valid at t+2.
  - Back-to-back commands: minimum one IDLE cycle between eop accept and next sop.

Test Plan:
- addr=0x3000_0000, len=8, data words 0..: one TLP of 2 beats.
  - Beat0[31:0]=0x6000_0008, beat0[63:48]=req_id, beat0 tag=0, DW3=0x3000_0000.
  - Beat1 eop, empty=2.
  - tlp_count=1.
- len=64, 16-bit counting payload, tx_st_ready random 70%: 9 beats; reassembled payload 0x0000..0x007F contiguous; signals stable under stall.
- data_valid dropped for 5 cycles after beat 3: bubbles appear; payload identical to the no-gap run.
- 257 back-to-back len=8 commands: tags 0..255,0; tlp_count=257; sop/eop pairing never broken.
- Invalid commands (len=12 → not a multiple of 8; len=8 with addr=0x10 → misaligned; len=0) -> err_cmd=1, no tx_st_valid, data_ready stays 0, cmd_ready returns 1 next cycle.
- Reset asserted on beat 2 of a len=32 TLP -> outputs 0 the next cycle; tag and tlp_count 0; the following command produces a clean TLP with tag 0.
